// File: rtl/write_combine_buffer.sv
// Write-combining buffer: merges masked word writes into one block-wide line
// and hands the line downstream on block change, full line, idle timeout or flush.
module write_combine_buffer #(
  parameter int unsigned ADDRESSIZE    = 32,
  parameter int unsigned WORDSIZE      = 32,
  parameter int unsigned OFFSETBITS    = 2,
  parameter int unsigned BLOCKSIZE     = 16,
  parameter int unsigned BLOCKSIZE_log = 4,
  parameter int unsigned TIMEOUT       = 15,
  parameter int unsigned TIMEOUT_log   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDRESSIZE-1:0]           wr_addr,
  input  logic [WORDSIZE-1:0]             wr_data,
  input  logic [WORDSIZE-1:0]             wr_mask,
  input  logic                            flush_req,
  output logic                            blk_valid,
  input  logic                            blk_ready,
  output logic [ADDRESSIZE-1:0]           blk_addr,
  output logic [BLOCKSIZE*WORDSIZE-1:0]   blk_data,
  output logic [BLOCKSIZE*WORDSIZE-1:0]   blk_mask,
  output logic                            busy
);

  localparam int unsigned LINE_LSB = OFFSETBITS + BLOCKSIZE_log;
  localparam int unsigned TAG_W    = ADDRESSIZE - LINE_LSB;
  localparam int unsigned LINE_W   = BLOCKSIZE * WORDSIZE;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [LINE_W-1:0]      data_q, data_d;
  logic [LINE_W-1:0]      mask_q, mask_d;
  logic [TIMEOUT_log-1:0] cnt_q, cnt_d;
  logic                   blk_valid_q;
  logic                   busy_q;

  logic [TAG_W-1:0]         wr_tag;
  logic [BLOCKSIZE_log-1:0] wr_idx;
  logic                     tag_match;
  logic                     accept;
  logic                     timeout_hit;
  logic [LINE_W-1:0]        base_data, base_mask;
  logic [LINE_W-1:0]        merged_data, merged_mask;
  logic                     unused_addr_bits;

  assign wr_tag           = wr_addr[ADDRESSIZE-1:LINE_LSB];
  assign wr_idx           = wr_addr[LINE_LSB-1:OFFSETBITS];
  assign tag_match        = (wr_tag == tag_q);
  assign unused_addr_bits = ^wr_addr[OFFSETBITS-1:0];

  // Merge the incoming word into the line; a new line starts from all zeros.
  always_comb begin
    base_data   = (state_q == ST_EMPTY) ? '0 : data_q;
    base_mask   = (state_q == ST_EMPTY) ? '0 : mask_q;
    merged_data = base_data;
    merged_mask = base_mask;
    for (int unsigned i = 0; i < BLOCKSIZE; i++) begin
      if (wr_idx == BLOCKSIZE_log'(i)) begin
        merged_data[i*WORDSIZE +: WORDSIZE] =
          (base_data[i*WORDSIZE +: WORDSIZE] & ~wr_mask) | (wr_data & wr_mask);
        merged_mask[i*WORDSIZE +: WORDSIZE] =
          base_mask[i*WORDSIZE +: WORDSIZE] | wr_mask;
      end
    end
  end

  // Next-state, line update and write-side handshake.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    wr_ready    = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          data_d  = merged_data;
          mask_d  = merged_mask;
          tag_d   = wr_tag;
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        wr_ready = tag_match;
        accept   = wr_valid && tag_match;
        if (accept) begin
          data_d = merged_data;
          mask_d = merged_mask;
          cnt_d  = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TIMEOUT_log'(1);
        end
        timeout_hit = (TIMEOUT != 0) && !accept && (cnt_q == TIMEOUT_log'(TIMEOUT));
        if (flush_req || (wr_valid && !tag_match) || (&mask_d) || timeout_hit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (blk_ready) begin
          data_d  = '0;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      tag_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      blk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      blk_valid_q <= (state_d == ST_DRAIN);
      busy_q      <= (state_d != ST_EMPTY);
    end
  end

  assign blk_valid = blk_valid_q;
  assign busy      = busy_q;
  assign blk_data  = data_q;
  assign blk_mask  = mask_q;
  assign blk_addr  = {tag_q, {LINE_LSB{1'b0}}};

endmodule
